// File: rtl/counter_pkg.sv
// Shared definitions for the count-sequence checker: state encoding and parameter defaults.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    MISS  = 2'd2
  } state_e;

  localparam int WIDTH_DEF    = 128;
  localparam int ERR_W_DEF    = 16;
  localparam int RELOCK_N_DEF = 4;
  // Miss counter must hold RELOCK_N up to 15.
  localparam int MISS_W       = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, synchronous active-low reset.
module sat_counter
  import counter_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  logic [ERR_W-1:0] count_q;
  logic [ERR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter128_check_sync_resetb.sv
// Checks that sampled values follow an incrementing count; flags mismatches and wraps,
// and relocks onto the incoming sequence after RELOCK_N consecutive mismatches.
module counter128_check_sync_resetb
  import counter_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int RELOCK_N = RELOCK_N_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             locked,
  output logic             error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [MISS_W-1:0] RELOCK_CNT = MISS_W'(RELOCK_N);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    expected_q, expected_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                prev_ones_q, prev_ones_d;
  logic                locked_q, locked_d;
  logic                error_q, error_d;
  logic                wrap_q, wrap_d;
  logic                err_inc;

  logic [WIDTH-1:0]    exp_inc;
  logic [WIDTH-1:0]    relock_val;
  logic [MISS_W-1:0]   miss_inc;
  logic                match;

  assign exp_inc    = expected_q + WIDTH'(1);
  assign relock_val = data_in + WIDTH'(1);
  assign miss_inc   = miss_q + MISS_W'(1);
  assign match      = (data_in == expected_q);

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    miss_d      = miss_q;
    prev_ones_d = prev_ones_q;
    error_d     = 1'b0;
    wrap_d      = 1'b0;
    err_inc     = 1'b0;

    if (valid) begin
      prev_ones_d = &data_in;
      case (state_q)
        IDLE: begin
          expected_d = relock_val;
          miss_d     = '0;
          state_d    = TRACK;
        end
        TRACK, MISS: begin
          if (match) begin
            expected_d = exp_inc;
            miss_d     = '0;
            state_d    = TRACK;
            wrap_d     = (expected_q == '0) && prev_ones_q;
          end else begin
            error_d = 1'b1;
            err_inc = 1'b1;
            // miss_q is always 0 in TRACK, so this also covers RELOCK_N == 1.
            if (miss_inc >= RELOCK_CNT) begin
              expected_d = relock_val;
              miss_d     = '0;
              state_d    = TRACK;
            end else begin
              expected_d = exp_inc;
              miss_d     = miss_inc;
              state_d    = MISS;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    locked_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      miss_q      <= '0;
      prev_ones_q <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      miss_q      <= miss_d;
      prev_ones_q <= prev_ones_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      wrap_q      <= wrap_d;
    end
  end

  sat_counter #(
    .ERR_W(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .resetb (resetb),
    .inc    (err_inc),
    .count  (err_count)
  );

  assign locked   = locked_q;
  assign error    = error_q;
  assign wrap     = wrap_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_counter128_check_sync_resetb.sv
// Randomized and directed bench for the count-sequence checker, with a behavioural reference model.
module tb_counter128_check_sync_resetb;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         resetb;
  logic         valid;
  logic [W-1:0] data_in;

  logic         locked_a, error_a, wrap_a;
  logic [15:0]  err_count_a;
  logic [W-1:0] expected_a;
  logic         locked_b, error_b, wrap_b;
  logic [1:0]   err_count_b;
  logic [W-1:0] expected_b;

  always #5 clk = ~clk;

  counter128_check_sync_resetb #(.WIDTH(W), .ERR_W(16), .RELOCK_N(4)) dut_a (
    .clk(clk), .resetb(resetb), .valid(valid), .data_in(data_in),
    .locked(locked_a), .error(error_a), .wrap(wrap_a),
    .err_count(err_count_a), .expected(expected_a)
  );

  counter128_check_sync_resetb #(.WIDTH(W), .ERR_W(2), .RELOCK_N(4)) dut_b (
    .clk(clk), .resetb(resetb), .valid(valid), .data_in(data_in),
    .locked(locked_b), .error(error_b), .wrap(wrap_b),
    .err_count(err_count_b), .expected(expected_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit           m_locked;
  int           m_miss;
  logic [W-1:0] m_exp;
  int           m_err_a, m_err_b;
  bit           m_prev_ones, m_error, m_wrap;
  logic [W-1:0] all1;

  int pulses_a, pulses_b, wraps_a;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rb, input logic v, input logic [W-1:0] d);
    m_error = 0;
    m_wrap  = 0;
    if (!rb) begin
      m_locked = 0; m_miss = 0; m_exp = '0;
      m_err_a = 0; m_err_b = 0; m_prev_ones = 0;
    end else if (v) begin
      if (!m_locked) begin
        m_exp    = d + 1;
        m_locked = 1;
        m_miss   = 0;
      end else if (d == m_exp) begin
        m_wrap = (m_exp == 0) && m_prev_ones;
        m_exp  = m_exp + 1;
        m_miss = 0;
      end else begin
        m_error = 1;
        if (m_err_a < 65535) m_err_a++;
        if (m_err_b < 3) m_err_b++;
        m_miss++;
        if (m_miss >= 4) begin
          m_exp  = d + 1;
          m_miss = 0;
        end else begin
          m_exp = m_exp + 1;
        end
      end
      m_prev_ones = (d == all1);
    end
  endtask

  task automatic check_outputs();
    chk("locked_a",   W'(locked_a),    W'(m_locked));
    chk("error_a",    W'(error_a),     W'(m_error));
    chk("wrap_a",     W'(wrap_a),      W'(m_wrap));
    chk("errcnt_a",   W'(err_count_a), W'(m_err_a));
    chk("expected_a", expected_a,      m_exp);
    chk("locked_b",   W'(locked_b),    W'(m_locked));
    chk("error_b",    W'(error_b),     W'(m_error));
    chk("wrap_b",     W'(wrap_b),      W'(m_wrap));
    chk("errcnt_b",   W'(err_count_b), W'(m_err_b));
    chk("expected_b", expected_b,      m_exp);
  endtask

  task automatic cycle(input logic rb, input logic v, input logic [W-1:0] d);
    @(negedge clk);
    resetb  = rb;
    valid   = v;
    data_in = d;
    @(posedge clk);
    model_step(rb, v, d);
    #1;
    if (error_a) pulses_a++;
    if (error_b) pulses_b++;
    if (wrap_a)  wraps_a++;
    check_outputs();
  endtask

  task automatic clear_counts();
    pulses_a = 0; pulses_b = 0; wraps_a = 0;
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    all1 = '1;
    resetb = 1'b0; valid = 1'b0; data_in = '0;
    clear_counts();
    model_step(1'b0, 1'b0, '0);

    // reset state
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    chk("rst_locked", W'(locked_a), '0);
    chk("rst_error", W'(error_a), '0);
    chk("rst_wrap", W'(wrap_a), '0);
    chk("rst_errcnt", W'(err_count_a), '0);
    chk("rst_expected", expected_a, '0);

    // lock on 5, track 6,7,8
    clear_counts();
    cycle(1, 1, 5);
    chk("lock_first", W'(locked_a), 1);
    cycle(1, 1, 6); cycle(1, 1, 7); cycle(1, 1, 8);
    chk("seq_pulses", W'(pulses_a), 0);
    chk("seq_errcnt", W'(err_count_a), 0);
    chk("seq_expected", expected_a, 9);

    // single mismatch on 99, recover on 13
    cycle(1, 1, 9);
    clear_counts();
    cycle(1, 1, 10); cycle(1, 1, 11);
    cycle(1, 1, 99);
    chk("err_on_99", W'(error_a), 1);
    cycle(1, 1, 13);
    chk("recover_err", W'(error_a), 0);
    chk("recover_pulses", W'(pulses_a), 1);
    chk("recover_errcnt", W'(err_count_a), 1);
    chk("recover_expected", expected_a, 14);

    // wrap through all-ones
    cycle(0, 0, '0);
    cycle(1, 1, all1 - 2);
    clear_counts();
    cycle(1, 1, all1 - 1);
    cycle(1, 1, all1);
    chk("prewrap_wrap", W'(wrap_a), 0);
    chk("prewrap_exp", expected_a, '0);
    cycle(1, 1, '0);
    chk("wrap_pulse", W'(wrap_a), 1);
    chk("wrap_expected", expected_a, 1);
    chk("wrap_pulses_err", W'(pulses_a), 0);
    cycle(1, 0, '0);
    chk("wrap_one_cycle", W'(wrap_a), 0);

    // four mismatches force a relock
    cycle(0, 0, '0);
    cycle(1, 1, 19);
    chk("at20", expected_a, 20);
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, W'(500 + i));
      chk("relock_err", W'(error_a), 1);
    end
    chk("relock_pulses", W'(pulses_a), 4);
    chk("relock_expected", expected_a, 504);
    chk("relock_errcnt_a", W'(err_count_a), 4);
    chk("relock_errcnt_b", W'(err_count_b), 3);
    cycle(1, 1, 504);
    chk("post_relock_err", W'(error_a), 0);
    chk("post_relock_exp", expected_a, 505);

    // idle gap of 50 cycles mid-track
    clear_counts();
    for (int i = 0; i < 50; i++) cycle(1, 0, rand_word());
    chk("gap_expected", expected_a, 505);
    chk("gap_errcnt", W'(err_count_a), 4);
    chk("gap_pulses", W'(pulses_a), 0);
    chk("gap_wraps", W'(wraps_a), 0);
    chk("gap_locked", W'(locked_a), 1);
    cycle(1, 1, 505);
    chk("gap_resume_err", W'(error_a), 0);
    chk("gap_resume_exp", expected_a, 506);

    // saturation of the narrow error counter
    cycle(0, 0, '0);
    cycle(1, 1, '0);
    clear_counts();
    for (int i = 0; i < 5; i++) cycle(1, 1, 777);
    chk("sat_pulses_b", W'(pulses_b), 5);
    chk("sat_errcnt_b", W'(err_count_b), 3);
    chk("sat_errcnt_a", W'(err_count_a), 5);

    // reset wins over a valid sample
    cycle(0, 1, rand_word());
    chk("rstv_locked", W'(locked_a), 0);
    chk("rstv_error", W'(error_a), 0);
    chk("rstv_wrap", W'(wrap_a), 0);
    chk("rstv_errcnt", W'(err_count_b), 0);
    chk("rstv_expected", expected_a, '0);
    cycle(1, 1, 42);
    chk("relock_after_rst_err", W'(error_a), 0);
    chk("relock_after_rst_lock", W'(locked_a), 1);
    chk("relock_after_rst_exp", expected_a, 43);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r, s;
      logic [W-1:0] d;
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 99);
      if (s < 60)      d = m_exp;
      else if (s < 80) d = rand_word();
      else if (s < 90) d = all1 - W'($urandom_range(0, 3));
      else             d = W'($urandom_range(0, 7));
      cycle((r != 0), ($urandom_range(0, 3) != 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
